// File: rtl/cv32e41p_pkg.sv
// Types and constants shared by the hardware-loop register file and its controller.
package cv32e41p_pkg;

    localparam int HWLP_N_REGS = 2;

    typedef enum logic [0:0] {
        HWLP_IDLE = 1'b0,
        HWLP_JUMP = 1'b1
    } hwlp_ctrl_state_e;

    // Index width for an N-entry loop set; never collapses to zero bits.
    function automatic int hwlp_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cv32e41p_hwloop_match.sv
// End-address comparators plus priority encoder: picks the innermost active loop
// whose last instruction is the one currently in ID.
module cv32e41p_hwloop_match
    import cv32e41p_pkg::*;
#(
    parameter int N_REGS = HWLP_N_REGS,
    parameter int IDX_W  = hwlp_idx_w(N_REGS)
) (
    input  logic [31:0]             pc,
    input  logic [N_REGS-1:0][31:0] end_addr,
    input  logic [N_REGS-1:0][31:0] counter,
    output logic                    sel_valid,
    output logic [IDX_W-1:0]        sel_idx,
    output logic                    sel_last
);

    logic [N_REGS-1:0] match;

    always_comb begin
        for (int k = 0; k < N_REGS; k++) begin
            match[k] = (pc == end_addr[k]) && (counter[k] != 32'd0);
        end
    end

    // Scan from the outermost loop inwards so the lowest matching index wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_last  = 1'b0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (match[k]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(k);
                sel_last  = (counter[k] == 32'd1);
            end
        end
    end

endmodule

// File: rtl/cv32e41p_hwloop_ctrl.sv
// Hardware-loop controller: decides back-jumps at loop ends, drives the decrement
// strobes and holds the jump request to the prefetcher until it is accepted.
module cv32e41p_hwloop_ctrl
    import cv32e41p_pkg::*;
#(
    parameter int N_REGS = HWLP_N_REGS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             id_pc_i,
    input  logic                    id_valid_i,
    input  logic                    flush_i,
    input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
    input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
    input  logic [N_REGS-1:0][31:0] hwlp_counter_i,
    input  logic                    fetch_ready_i,
    output logic [N_REGS-1:0]       hwlp_dec_cnt_o,
    output logic                    hwlp_jump_o,
    output logic [31:0]             hwlp_targ_addr_o,
    output logic                    hwlp_busy_o
);

    localparam int IDX_W = hwlp_idx_w(N_REGS);

    hwlp_ctrl_state_e state_q, state_d;
    logic [31:0]      targ_q, targ_d;

    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_last;
    logic             decide;

    cv32e41p_hwloop_match #(
        .N_REGS (N_REGS),
        .IDX_W  (IDX_W)
    ) u_match (
        .pc        (id_pc_i),
        .end_addr  (hwlp_end_addr_i),
        .counter   (hwlp_counter_i),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx),
        .sel_last  (sel_last)
    );

    // Only a retiring, unflushed instruction seen while no jump is pending may act.
    assign decide = id_valid_i && !flush_i && (state_q == HWLP_IDLE) && sel_valid;

    always_comb begin
        hwlp_dec_cnt_o = '0;
        if (decide) begin
            hwlp_dec_cnt_o[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        targ_d  = targ_q;
        case (state_q)
            HWLP_IDLE: begin
                if (decide && !sel_last) begin
                    state_d = HWLP_JUMP;
                    targ_d  = hwlp_start_addr_i[sel_idx];
                end
            end
            HWLP_JUMP: begin
                // A flush drops the request; the decrement already issued stands.
                if (flush_i || fetch_ready_i) begin
                    state_d = HWLP_IDLE;
                end
            end
            default: state_d = HWLP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HWLP_IDLE;
            targ_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            targ_q  <= targ_d;
        end
    end

    assign hwlp_jump_o      = (state_q == HWLP_JUMP);
    assign hwlp_busy_o      = (state_q == HWLP_JUMP);
    assign hwlp_targ_addr_o = targ_q;

endmodule

// File: doc/cv32e41p_hwloop_ctrl.md
# cv32e41p_hwloop_ctrl

Hardware-loop controller: the consumer side of the hardware-loop register file. It compares the PC of the instruction retiring from ID against each loop's end address and decides whether to branch back to the loop start. It requests the back-jump from the prefetcher with a held request/acknowledge handshake, and drives the per-loop decrement strobes that the register file applies on `valid_i`. Sits between the ID stage, the hwloop register file and the prefetch buffer.

## Interface
- `N_REGS`, 2: number of hardware loops; index 0 is the innermost and highest priority.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `id_pc_i`  in  32  PC of the instruction currently in ID
- `id_valid_i`  in  1  instruction in ID retires this cycle; same signal as the register file's `valid_i`
- `flush_i`  in  1  branch/exception/debug redirect; kills any pending hwloop jump
- `hwlp_start_addr_i`  in  N_REGS×32  loop start addresses
- `hwlp_end_addr_i`  in  N_REGS×32  address of the last instruction of each loop body
- `hwlp_counter_i`  in  N_REGS×32  remaining iterations; 0 means the loop is inactive
- `fetch_ready_i`  in  1  prefetcher accepts the jump this cycle
- `hwlp_dec_cnt_o`  out  N_REGS  one-hot-or-zero decrement strobe to the register file
- `hwlp_jump_o`  out  1  jump request to the prefetcher
- `hwlp_targ_addr_o`  out  32  jump target; stable while `hwlp_jump_o`=1
- `hwlp_busy_o`  out  1  a jump is pending; ID must not issue past the loop end

## Operation
- Per loop k, `match[k]` = (`id_pc_i` == `hwlp_end_addr_i[k]`) && (`hwlp_counter_i[k]` != 0).
- Selected loop: the lowest k with `match[k]`. No match means no action.
- Decision is evaluated only when `id_valid_i`=1, state=IDLE and `flush_i`=0.
  - Selected counter == 1: last iteration. `hwlp_dec_cnt_o[k]`=1 (counter reaches 0) and no jump is taken.
  - Selected counter > 1: `hwlp_dec_cnt_o[k]`=1; `targ_q` ← `hwlp_start_addr_i[k]`; next state is JUMP.
- Shared end address: only the lowest matching loop is decremented, so at most one strobe is set per cycle. Software must not let two active loops share an end address; this behaviour is defined so hardware stays deterministic.
- FSM states:
  - IDLE: `hwlp_jump_o`=0, `busy`=0.
  - JUMP: `hwlp_jump_o`=1, `busy`=1, `hwlp_targ_addr_o`=`targ_q`.
- JUMP→IDLE when `fetch_ready_i`=1 (handshake done) or `flush_i`=1 (request dropped; the decrement already applied is not undone).
- In JUMP, `hwlp_dec_cnt_o`=0 regardless of `id_valid_i`.
- `hwlp_dec_cnt_o` is 0 whenever `id_valid_i`=0 or `flush_i`=1.
- Counter widths are 32-bit unsigned. The block never decrements a zero counter; wrap-around is impossible by construction.

## Timing
- Reset values: state IDLE, `targ_q`=0, `hwlp_jump_o`=0, `hwlp_targ_addr_o`=0, `hwlp_busy_o`=0, `hwlp_dec_cnt_o`=0.
- `hwlp_dec_cnt_o` is combinational, asserted in the same cycle as `id_valid_i`. The register file updates on that clock edge.
- `hwlp_jump_o` rises one cycle after the deciding retire, from the registered state. It stays high with a constant target until the cycle where `fetch_ready_i`=1 inclusive, then falls the next cycle.
- Minimum spacing between two jumps is 2 cycles: decide, then jump/ack. A one-instruction body therefore iterates at most every 2 cycles. Counter inputs seen after the JUMP are the already-decremented values.
- `flush_i` and `fetch_ready_i` in the same JUMP cycle: flush wins, and the jump is counted as not accepted by the prefetcher.
- Reset asserted mid-JUMP: outputs drop to reset values asynchronously.

## Structure
- Shared package `cv32e41p_pkg`: FSM enum `hwlp_ctrl_state_e` {HWLP_IDLE, HWLP_JUMP}; constant `HWLP_N_REGS`=2 used by both this block and the register file.
- Sub-module `cv32e41p_hwloop_match`: per-loop comparator plus priority encoder. Outputs `sel_valid`, `sel_idx`, `sel_last`; purely combinational.
- The FSM, `targ_q` and strobe gating live in the top module.

## Test plan
- Loop 0: start 0x100, end 0x10C, counter 3, retire 0x10C → `dec_cnt`=01 that cycle; next cycle `jump`=1, target 0x100; with `fetch_ready` held 0 for 3 cycles, target stays 0x100 until ack.
- Counter 1 at end 0x10C, retire → `dec_cnt`=01, `jump` never asserts; a following retire at 0x10C with counter 0 → no strobe.
- Nested: loop0 end 0x120 counter 2, loop1 end 0x130 counter 5, retire 0x130 → `dec_cnt`=10, target = loop1 start.
- Both loops end at 0x140 with counters 4 and 4 → `dec_cnt`=01 only, target = loop0 start; assertion "≤1 strobe" holds.
- JUMP pending with `flush_i`=1 and `fetch_ready_i`=1 in the same cycle → back to IDLE next cycle, `jump` low; a retire at the end PC during JUMP produces no strobe.
- Assert `rst_n` low while in JUMP → `jump`/`busy`/target go to 0 immediately; after release, a first retire at end PC behaves as in scenario 1.
